// File: rtl/gray_counter_param.sv
// rtl/gray_counter_param.sv - parametrised Gray-code counter with load, direction, terminal count and wrap pulse
module gray_counter_param #(
    parameter int WIDTH    = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] gray_q;
    logic             wrap_q;
    logic [WIDTH-1:0] b_next;
    logic [WIDTH-1:0] load_bin;
    logic             wrap_next;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        load_bin = ALL_ZERO;
        for (int i = 0; i < WIDTH; i++) begin
            load_bin[i] = ^(load_gray >> i);
        end
    end

    assign tc = up_dn ? (b_q == ALL_ONES) : (b_q == ALL_ZERO);

    always_comb begin
        b_next    = b_q;
        wrap_next = 1'b0;
        if (load) begin
            b_next = load_bin;
        end else if (en) begin
            if (!(SATURATE && tc)) begin
                b_next    = up_dn ? (b_q + ONE) : (b_q - ONE);
                wrap_next = tc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_q    <= ALL_ZERO;
            gray_q <= ALL_ZERO;
            wrap_q <= 1'b0;
        end else begin
            b_q    <= b_next;
            gray_q <= b_next ^ (b_next >> 1);
            wrap_q <= wrap_next;
        end
    end

    assign gray = gray_q;
    assign bin  = b_q;
    assign wrap = wrap_q;

endmodule
